// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: word sizes, ALU op
// select positions and bus-driver priority slots (lower slot wins).
package datapath_pkg;

    localparam int unsigned BITS      = 32;
    localparam int unsigned REGISTERS = 16;
    localparam int unsigned ZBITS     = 2 * BITS;
    localparam int unsigned SHW       = $clog2(BITS);

    // ALU op select bit positions; lower index has priority
    localparam int unsigned OP_ADD    = 0;
    localparam int unsigned OP_SUB    = 1;
    localparam int unsigned OP_MUL    = 2;
    localparam int unsigned OP_DIV    = 3;
    localparam int unsigned OP_SHR    = 4;
    localparam int unsigned OP_SHL    = 5;
    localparam int unsigned OP_ROR    = 6;
    localparam int unsigned OP_ROL    = 7;
    localparam int unsigned OP_AND    = 8;
    localparam int unsigned OP_OR     = 9;
    localparam int unsigned OP_NEGATE = 10;
    localparam int unsigned OP_NOT    = 11;
    localparam int unsigned NUM_OPS   = 12;

    // Bus driver slots in priority order; general registers follow R15 first
    localparam int unsigned SRC_MDR    = 0;
    localparam int unsigned SRC_LO     = 1;
    localparam int unsigned SRC_HI     = 2;
    localparam int unsigned SRC_ZHI    = 3;
    localparam int unsigned SRC_ZLO    = 4;
    localparam int unsigned SRC_PC     = 5;
    localparam int unsigned SRC_GR_TOP = 6;
    localparam int unsigned NUM_SRC    = SRC_GR_TOP + REGISTERS;

    function automatic int unsigned gr_src(input int unsigned idx);
        return SRC_GR_TOP + (REGISTERS - 1 - idx);
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from RY, B from the bus, 64-bit result for Z.
// With no op selected it produces B+1 (PC increment).
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [BITS-1:0]    a_i,
    input  logic [BITS-1:0]    b_i,
    input  logic [NUM_OPS-1:0] op_i,
    output logic [ZBITS-1:0]   result_c_o
);

    localparam logic [SHW:0] BITS_W = (SHW + 1)'(BITS);

    logic signed [ZBITS-1:0] a_sx;
    logic signed [ZBITS-1:0] b_sx;
    logic signed [ZBITS-1:0] b_div;
    logic signed [ZBITS-1:0] prod;
    logic signed [ZBITS-1:0] quo;
    logic signed [ZBITS-1:0] rem;
    logic [SHW-1:0]          sh;
    logic [BITS-1:0]         ror_c;
    logic [BITS-1:0]         rol_c;
    logic                    unused_div_c;

    // Divide at double width so MIN/-1 cannot overflow; zero divisor is masked later
    assign a_sx  = ZBITS'($signed(a_i));
    assign b_sx  = ZBITS'($signed(b_i));
    assign b_div = (b_i == '0) ? {{(ZBITS-1){1'b0}}, 1'b1} : b_sx;
    assign prod  = a_sx * b_sx;
    assign quo   = a_sx / b_div;
    assign rem   = a_sx % b_div;

    assign sh    = b_i[SHW-1:0];
    assign ror_c = (a_i >> sh) | (a_i << (BITS_W - {1'b0, sh}));
    assign rol_c = (a_i << sh) | (a_i >> (BITS_W - {1'b0, sh}));

    assign unused_div_c = ^{quo[ZBITS-1:BITS], rem[ZBITS-1:BITS]};

    always_comb begin
        result_c_o = {{BITS{1'b0}}, b_i + BITS'(1)};
        if (op_i[OP_ADD]) begin
            result_c_o = {{BITS{1'b0}}, a_i + b_i};
        end else if (op_i[OP_SUB]) begin
            result_c_o = {{BITS{1'b0}}, a_i - b_i};
        end else if (op_i[OP_MUL]) begin
            result_c_o = prod;
        end else if (op_i[OP_DIV]) begin
            result_c_o = (b_i == '0) ? '0 : {rem[BITS-1:0], quo[BITS-1:0]};
        end else if (op_i[OP_SHR]) begin
            result_c_o = {{BITS{1'b0}}, a_i >> sh};
        end else if (op_i[OP_SHL]) begin
            result_c_o = {{BITS{1'b0}}, a_i << sh};
        end else if (op_i[OP_ROR]) begin
            result_c_o = {{BITS{1'b0}}, ror_c};
        end else if (op_i[OP_ROL]) begin
            result_c_o = {{BITS{1'b0}}, rol_c};
        end else if (op_i[OP_AND]) begin
            result_c_o = {{BITS{1'b0}}, a_i & b_i};
        end else if (op_i[OP_OR]) begin
            result_c_o = {{BITS{1'b0}}, a_i | b_i};
        end else if (op_i[OP_NEGATE]) begin
            result_c_o = {{BITS{1'b0}}, -b_i};
        end else if (op_i[OP_NOT]) begin
            result_c_o = {{BITS{1'b0}}, ~b_i};
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: general registers, PC/IR/MAR/MDR/HI/LO/RY,
// 64-bit Z, and a priority bus mux, all strobed by an external control unit.
module datapath
    import datapath_pkg::*;
(
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      R0in,  R1in,  R2in,  R3in,
    input  logic                      R4in,  R5in,  R6in,  R7in,
    input  logic                      R8in,  R9in,  R10in, R11in,
    input  logic                      R12in, R13in, R14in, R15in,
    input  logic                      PCin,  IRin,  RYin,  MARin,
    input  logic                      HIin,  LOin,  RZin,  MDRin,
    input  logic                      Read,
    input  logic                      MDRout, LOout, HIout, Zhighout, Zlowout, PCout,
    input  logic                      R0out,  R1out,  R2out,  R3out,
    input  logic                      R4out,  R5out,  R6out,  R7out,
    input  logic                      R8out,  R9out,  R10out, R11out,
    input  logic                      R12out, R13out, R14out, R15out,
    input  logic                      ADD, SUB, MUL, DIV, SHR, SHL,
    input  logic                      ROR, ROL, AND, OR, NEGATE, NOT,
    input  logic [BITS-1:0]           Mdatain,
    output logic [BITS*REGISTERS-1:0] genRegisterStream,
    output logic [BITS-1:0]           bus
);

    logic [REGISTERS-1:0] gr_in_c;
    logic [REGISTERS-1:0] gr_out_c;
    logic [NUM_OPS-1:0]   op_c;

    logic [BITS-1:0]  gr_q [REGISTERS];
    logic [BITS-1:0]  pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, ry_q;
    logic [ZBITS-1:0] z_q;
    logic [ZBITS-1:0] z_d;
    logic [BITS-1:0]  mdr_d;
    logic [BITS-1:0]  bus_c;
    logic [BITS-1:0]  src_c [NUM_SRC];
    logic [NUM_SRC-1:0] sel_c;
    logic             unused_regs_c;

    assign gr_in_c  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                       R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign gr_out_c = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign op_c     = {NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD};

    assign src_c[SRC_MDR] = mdr_q;
    assign src_c[SRC_LO]  = lo_q;
    assign src_c[SRC_HI]  = hi_q;
    assign src_c[SRC_ZHI] = z_q[ZBITS-1:BITS];
    assign src_c[SRC_ZLO] = z_q[BITS-1:0];
    assign src_c[SRC_PC]  = pc_q;
    assign sel_c[SRC_MDR] = MDRout;
    assign sel_c[SRC_LO]  = LOout;
    assign sel_c[SRC_HI]  = HIout;
    assign sel_c[SRC_ZHI] = Zhighout;
    assign sel_c[SRC_ZLO] = Zlowout;
    assign sel_c[SRC_PC]  = PCout;

    for (genvar g = 0; g < REGISTERS; g++) begin : g_gr
        assign src_c[gr_src(g)]                = gr_q[g];
        assign sel_c[gr_src(g)]                = gr_out_c[g];
        assign genRegisterStream[g*BITS +: BITS] = gr_q[g];
    end

    // Scan lowest priority first so the highest-priority active driver wins
    always_comb begin
        bus_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (sel_c[i]) begin
                bus_c = src_c[i];
            end
        end
    end

    assign bus   = bus_c;
    assign mdr_d = Read ? Mdatain : bus_c;

    datapath_alu u_alu (
        .a_i        (ry_q),
        .b_i        (bus_c),
        .op_i       (op_c),
        .result_c_o (z_d)
    );

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            for (int i = 0; i < int'(REGISTERS); i++) begin
                gr_q[i] <= '0;
            end
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            ry_q  <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < int'(REGISTERS); i++) begin
                if (gr_in_c[i]) gr_q[i] <= bus_c;
            end
            if (PCin)  pc_q  <= bus_c;
            if (IRin)  ir_q  <= bus_c;
            if (MARin) mar_q <= bus_c;
            if (HIin)  hi_q  <= bus_c;
            if (LOin)  lo_q  <= bus_c;
            if (RYin)  ry_q  <= bus_c;
            if (MDRin) mdr_q <= mdr_d;
            if (RZin)  z_q   <= z_d;
        end
    end

    // IR and MAR are consumed outside this slice and are deliberately not exported
    assign unused_regs_c = ^{ir_q, mar_q};

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus pushes expected bus/register
// values computed by a behavioural model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_datapath;

    localparam int O_ADD = 0, O_SUB = 1, O_MUL = 2, O_DIV = 3, O_SHR = 4, O_SHL = 5;
    localparam int O_ROR = 6, O_ROL = 7, O_AND = 8, O_OR = 9, O_NEG = 10, O_NOT = 11;

    logic         clk;
    logic         clear_n;
    logic [15:0]  rin, rout;
    logic         pcin, irin, ryin, marin, hiin, loin, rzin, mdrin, rd;
    logic         mdrout, loout, hiout, zhout, zlout, pcout;
    logic [11:0]  ops;
    logic [31:0]  mdatain;
    logic [511:0] stream;
    logic [31:0]  bus_w;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_gr [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_ry;
    logic [63:0] m_z;

    // Scoreboard queues
    string        eq_name [$];
    logic [31:0]  eq_bus [$];
    logic [511:0] eq_stream [$];
    logic [31:0]  eq_ir [$];
    logic [31:0]  eq_mar [$];

    datapath dut (
        .Clock(clk), .Clear(clear_n),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .PCin(pcin), .IRin(irin), .RYin(ryin), .MARin(marin),
        .HIin(hiin), .LOin(loin), .RZin(rzin), .MDRin(mdrin), .Read(rd),
        .MDRout(mdrout), .LOout(loout), .HIout(hiout), .Zhighout(zhout),
        .Zlowout(zlout), .PCout(pcout),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .ADD(ops[O_ADD]), .SUB(ops[O_SUB]), .MUL(ops[O_MUL]), .DIV(ops[O_DIV]),
        .SHR(ops[O_SHR]), .SHL(ops[O_SHL]), .ROR(ops[O_ROR]), .ROL(ops[O_ROL]),
        .AND(ops[O_AND]), .OR(ops[O_OR]), .NEGATE(ops[O_NEG]), .NOT(ops[O_NOT]),
        .Mdatain(mdatain),
        .genRegisterStream(stream),
        .bus(bus_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_bus();
        if (mdrout) return m_mdr;
        if (loout)  return m_lo;
        if (hiout)  return m_hi;
        if (zhout)  return m_z[63:32];
        if (zlout)  return m_z[31:0];
        if (pcout)  return m_pc;
        for (int i = 15; i >= 0; i--) begin
            if (rout[i]) return m_gr[i];
        end
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [11:0] op);
        longint sa, sb, q, r;
        logic [31:0] res;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        res = 32'h0;
        if (op[O_ADD]) return {32'h0, a + b};
        if (op[O_SUB]) return {32'h0, a - b};
        if (op[O_MUL]) return 64'(sa * sb);
        if (op[O_DIV]) begin
            if (b == 32'h0) return 64'h0;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        if (op[O_SHR]) return {32'h0, a >> n};
        if (op[O_SHL]) return {32'h0, a << n};
        if (op[O_ROR]) begin
            for (int k = 0; k < 32; k++) res[k] = a[(k + n) % 32];
            return {32'h0, res};
        end
        if (op[O_ROL]) begin
            for (int k = 0; k < 32; k++) res[(k + n) % 32] = a[k];
            return {32'h0, res};
        end
        if (op[O_AND]) return {32'h0, a & b};
        if (op[O_OR])  return {32'h0, a | b};
        if (op[O_NEG]) return {32'h0, 32'h0 - b};
        if (op[O_NOT]) return {32'h0, ~b};
        return {32'h0, b + 32'h1};
    endfunction

    function automatic logic [511:0] model_stream();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[i*32 +: 32] = m_gr[i];
        return s;
    endfunction

    task automatic clear_ctrl();
        clear_n = 1'b1;
        rin = '0; rout = '0; ops = '0;
        pcin = 0; irin = 0; ryin = 0; marin = 0; hiin = 0; loin = 0;
        rzin = 0; mdrin = 0; rd = 0;
        mdrout = 0; loout = 0; hiout = 0; zhout = 0; zlout = 0; pcout = 0;
    endtask

    // One clock cycle: queue the expected observation, then advance the model at the edge
    task automatic step(input string nm, input bit chk, input bit use_c, input logic [31:0] cbus);
        logic [31:0] b;
        logic [63:0] alu;
        b   = model_bus();
        alu = model_alu(m_ry, b, ops);
        if (chk) begin
            eq_name.push_back(nm);
            eq_bus.push_back(use_c ? cbus : b);
            eq_stream.push_back(model_stream());
            eq_ir.push_back(m_ir);
            eq_mar.push_back(m_mar);
        end
        @(posedge clk);
        if (!clear_n) begin
            for (int i = 0; i < 16; i++) m_gr[i] = 32'h0;
            m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_ry = 0; m_z = 0;
        end else begin
            for (int i = 0; i < 16; i++) if (rin[i]) m_gr[i] = b;
            if (pcin)  m_pc  = b;
            if (irin)  m_ir  = b;
            if (marin) m_mar = b;
            if (hiin)  m_hi  = b;
            if (loin)  m_lo  = b;
            if (ryin)  m_ry  = b;
            if (rzin)  m_z   = alu;
            if (mdrin) m_mdr = rd ? mdatain : b;
        end
        #1;
        clear_ctrl();
    endtask

    task automatic step_m(input string nm);
        step(nm, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic step_c(input string nm, input logic [31:0] want);
        step(nm, 1'b1, 1'b1, want);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        mdatain = v; rd = 1; mdrin = 1;
        step_m("ld_mdr");
    endtask

    task automatic alu_case(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input int opidx, input logic [31:0] want_lo, input logic [31:0] want_hi);
        load_mdr(a);
        mdrout = 1; ryin = 1;
        step_c({nm, "_ry"}, a);
        load_mdr(b);
        mdrout = 1; rzin = 1;
        if (opidx >= 0) ops[opidx] = 1'b1;
        step_c({nm, "_op"}, b);
        zlout = 1;
        step_c({nm, "_zlo"}, want_lo);
        zhout = 1;
        step_c({nm, "_zhi"}, want_hi);
    endtask

    task automatic cmp(input string nm, input string what, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %0h want %0h", nm, what, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (eq_name.size() > 0) begin
                string        nm;
                logic [31:0]  eb, ei, em;
                logic [511:0] es;
                nm = eq_name.pop_front();
                eb = eq_bus.pop_front();
                es = eq_stream.pop_front();
                ei = eq_ir.pop_front();
                em = eq_mar.pop_front();
                cmp(nm, "bus", 512'(bus_w), 512'(eb));
                cmp(nm, "regs", stream, es);
                cmp(nm, "ir", 512'(dut.ir_q), 512'(ei));
                cmp(nm, "mar", 512'(dut.mar_q), 512'(em));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_gr[i] = 32'h0;
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_ry = 0; m_z = 0;
        mdatain = 32'h0;
        clear_ctrl();
        clear_n = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1'b0, 1'b0, 32'h0);

        step_c("idle_after_reset", 32'h0);
        zlout = 1; step_c("zlo_after_reset", 32'h0);
        zhout = 1; step_c("zhi_after_reset", 32'h0);
        pcout = 1; step_c("pc_after_reset", 32'h0);

        load_mdr(32'h22); mdrout = 1; rin[2] = 1; step_c("ld_r2", 32'h22);
        load_mdr(32'h24); mdrout = 1; rin[4] = 1; step_c("ld_r4", 32'h24);
        load_mdr(32'h26); mdrout = 1; rin[5] = 1; step_c("ld_r5", 32'h26);
        rout[2] = 1; step_c("rd_r2", 32'h22);

        pcout = 1; marin = 1; rzin = 1; step_c("pc_to_z", 32'h0);
        zlout = 1; pcin = 1; step_c("z_to_pc", 32'h1);
        pcout = 1; step_c("pc_read", 32'h1);

        load_mdr(32'h4A920000); mdrout = 1; irin = 1; step_c("fetch_ir", 32'h4A920000);

        rout[2] = 1; ryin = 1; step_c("and_ry", 32'h22);
        rout[4] = 1; ops[O_AND] = 1; rzin = 1; step_c("and_op", 32'h24);
        zlout = 1; rin[5] = 1; step_c("and_wb", 32'h20);
        rout[5] = 1; step_c("rd_r5", 32'h20);

        alu_case("mul_neg", 32'hFFFFFFFF, 32'h2, O_MUL, 32'hFFFFFFFE, 32'hFFFFFFFF);
        alu_case("div",     32'h7,        32'h2, O_DIV, 32'h3,        32'h1);
        alu_case("div0",    32'h7,        32'h0, O_DIV, 32'h0,        32'h0);
        alu_case("rol",     32'h80000001, 32'h1, O_ROL, 32'h3,        32'h0);
        alu_case("ror",     32'h1,        32'h1, O_ROR, 32'h80000000, 32'h0);
        alu_case("shr",     32'h80000000, 32'd31, O_SHR, 32'h1,       32'h0);
        alu_case("add_wrap", 32'hFFFFFFFF, 32'h1, O_ADD, 32'h0,       32'h0);
        alu_case("inc_wrap", 32'h0, 32'hFFFFFFFF, -1,    32'h0,       32'h0);
        alu_case("sub",     32'h0,        32'h1, O_SUB, 32'hFFFFFFFF, 32'h0);
        alu_case("neg",     32'h9,        32'h5, O_NEG, 32'hFFFFFFFB, 32'h0);
        alu_case("prio_op", 32'h3,        32'h4, O_ADD, 32'h7,        32'h0);

        // RY loaded and Z captured together: ALU must see the old RY
        load_mdr(32'h5); mdrout = 1; ryin = 1; step_c("sim_ry5", 32'h5);
        load_mdr(32'hA); mdrout = 1; ryin = 1; rzin = 1; ops[O_ADD] = 1; step_c("sim_op", 32'hA);
        zlout = 1; step_c("sim_old_ry", 32'hF);
        load_mdr(32'h1); mdrout = 1; rzin = 1; ops[O_ADD] = 1; step_c("sim_new_op", 32'h1);
        zlout = 1; step_c("sim_new_ry", 32'hB);

        // Multiple drivers: MDR beats everything
        load_mdr(32'h5A); mdrout = 1; pcout = 1; zlout = 1; rout = 16'hFFFF; step_c("bus_prio", 32'h5A);
        pcout = 1; rout = 16'hFFFF; step_c("bus_prio_pc", 32'h1);
        rout[2] = 1; rout[5] = 1; step_c("bus_prio_gr", 32'h20);

        for (int i = 0; i < 600; i++) begin
            int sel, k;
            sel = int'($urandom_range(0, 25));
            case (sel)
                0: mdrout = 1;
                1: loout = 1;
                2: hiout = 1;
                3: zhout = 1;
                4: zlout = 1;
                5: pcout = 1;
                default: if (sel < 22) rout[sel - 6] = 1'b1;
            endcase
            if ($urandom_range(0, 7) == 0) rout[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 15) == 0) mdrout = 1;
            rin   = 16'($urandom & $urandom & $urandom);
            pcin  = ($urandom_range(0, 5) == 0);
            irin  = ($urandom_range(0, 5) == 0);
            ryin  = ($urandom_range(0, 3) == 0);
            marin = ($urandom_range(0, 5) == 0);
            hiin  = ($urandom_range(0, 5) == 0);
            loin  = ($urandom_range(0, 5) == 0);
            rzin  = ($urandom_range(0, 2) == 0);
            mdrin = ($urandom_range(0, 2) == 0);
            rd    = $urandom_range(0, 1) == 1;
            k = int'($urandom_range(0, 13));
            if (k < 12) ops[k] = 1'b1;
            else if (k == 13) ops = 12'($urandom);
            case ($urandom_range(0, 5))
                0: mdatain = 32'h0;
                1: mdatain = 32'hFFFFFFFF;
                2: mdatain = 32'h80000000;
                3: mdatain = 32'($urandom_range(0, 40));
                default: mdatain = $urandom;
            endcase
            clear_n = ($urandom_range(0, 99) != 0);
            step_m($sformatf("rnd%0d", i));
        end

        clear_n = 0; rin = 16'hFFFF; pcin = 1; step_m("late_reset");
        step_c("after_late_reset", 32'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (eq_name.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", eq_name.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
